// File: rtl/jt12_pres_ctrl.sv
// Prescaler register decode (0x2D/0x2E/0x2F) with tick-aligned apply of the divider
// setting, CPU busy countdown and registered write strobe for the register bank.
module jt12_pres_ctrl #(
    parameter int unsigned BUSY_CNT = 32
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       pres_tick,
    input  logic       write,
    input  logic       a0,
    input  logic       a1,
    input  logic [7:0] din,
    output logic [1:0] div_setting,
    output logic       busy,
    output logic       wr_stb,
    output logic       wr_a1,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SEL_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BUSY_CNT);
    localparam logic [SEL_W-1:0] SEL_RESET = 2'b10;

    logic             addr_wr;
    logic             data_wr;
    logic             pres_wr;
    logic [SEL_W-1:0] pend;
    logic [SEL_W-1:0] pend_nxt;
    logic             pend_vld;
    logic [CNT_W-1:0] cnt;

    assign addr_wr = write & ~a0;
    assign data_wr = write &  a0;

    // Prescaler address decode; the address phase alone updates the pending value
    always_comb begin
        pend_nxt = pend;
        pres_wr  = 1'b0;
        if (addr_wr && !a1) begin
            case (din)
                8'h2D: begin
                    pend_nxt = pend | 2'b10;
                    pres_wr  = 1'b1;
                end
                8'h2E: begin
                    pend_nxt = pend | 2'b01;
                    pres_wr  = 1'b1;
                end
                8'h2F: begin
                    pend_nxt = 2'b00;
                    pres_wr  = 1'b1;
                end
                default: begin
                    pend_nxt = pend;
                    pres_wr  = 1'b0;
                end
            endcase
        end
    end

    // A tick applies the value pending before this edge; a same-cycle write stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= SEL_RESET;
            pend_vld    <= 1'b0;
            div_setting <= SEL_RESET;
        end else begin
            pend <= pend_nxt;
            if (pres_tick && pend_vld) begin
                div_setting <= pend;
            end
            if (pres_wr) begin
                pend_vld <= 1'b1;
            end else if (pres_tick) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Register-bank write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_stb  <= 1'b0;
            wr_a1   <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
        end else begin
            wr_stb <= data_wr;
            if (addr_wr) begin
                wr_addr <= din;
                wr_a1   <= a1;
            end
            if (data_wr) begin
                wr_data <= din;
            end
        end
    end

    // Busy countdown in divider ticks; a reload beats a coincident tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            if (data_wr) begin
                cnt <= CNT_LOAD;
            end else if (pres_tick && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            busy <= (cnt != '0);
        end
    end

endmodule

// File: doc/jt12_pres_ctrl.md
# jt12_pres_ctrl

Prescaler configuration and write-sequencing controller for the FM/SSG/ADPCM clock divider. Decodes CPU address/data writes, implements the YM2608 prescaler registers 0x2D/0x2E/0x2F and drives the divider's 2-bit `div_setting`. A new setting is applied only on a divider tick, so no clock enable is ever truncated. The block also generates the CPU busy flag and a registered write strobe for the downstream register bank.

## Interface
- `BUSY_CNT`, default 32: number of divider ticks that busy stays high after a data write; legal range 1..63.
- `rst`  in  1  asynchronous, active-high reset.
- `clk`  in  1  system clock.
- `pres_tick`  in  1  divider output tick (FM prescaled enable); marks safe apply points and busy countdown.
- `write`  in  1  CPU write, one-`clk` pulse; sampled on every `clk` edge and not gated by cen.
- `a0`  in  1  0 = address write, 1 = data write.
- `a1`  in  1  register bank select; latched with the address.
- `din`  in  8  CPU data bus.
- `div_setting`  out  2  prescaler select to the divider.
- `busy`  out  1  CPU busy flag.
- `wr_stb`  out  1  one-cycle data-write strobe to the register bank.
- `wr_a1`  out  1  bank of the current write.
- `wr_addr`  out  8  latched register address.
- `wr_data`  out  8  write data.

## Operation
- **Reset values:**
  - `div_setting` = 2'b10 (FM 1/6, SSG 1/4); pending value `pend` = 2'b10; `pend_vld` = 0.
  - `busy` = 0, busy counter = 0.
  - `wr_stb` = 0; `wr_a1`, `wr_addr` and `wr_data` all 0.
- **Address write** (`write & !a0`):
  - `wr_addr <= din`, `wr_a1 <= a1`.
  - If `a1 = 0` and `din` is one of the prescaler addresses, the write takes effect on the address phase alone; the data value is irrelevant. The new pending value is computed from the current `pend`:
    - 0x2D: `pend <= pend | 2'b10`
    - 0x2E: `pend <= pend | 2'b01`
    - 0x2F: `pend <= 2'b00`
  - In each of these three cases `pend_vld <= 1`.
  - Any other address, or `a1 = 1`, leaves `pend` and `pend_vld` unchanged.
- **Data write** (`write & a0`):
  - `wr_data <= din`, `wr_stb <= 1` for exactly one cycle.
  - Busy counter `<= BUSY_CNT`.
  - Prescaler state is untouched.
- **Apply:** when `pres_tick & pend_vld`, `div_setting <= pend` and `pend_vld <= 0`.
- **Busy counter:** 6-bit, decrements by 1 on `pres_tick` while nonzero and saturates at 0. `busy` is registered, equal to (counter != 0).
- **Simultaneous events:**
  - Prescaler write and `pres_tick` in the same cycle: the tick applies the old `pend`. The new `pend` is stored and `pend_vld` stays 1, so it is applied on the next tick.
  - Data write and `pres_tick` in the same cycle: the reload wins, and the counter equals `BUSY_CNT`.
  - A data write while busy restarts the count.
- **Accumulation:** consecutive 0x2D and 0x2E writes before a tick accumulate, giving 2'b11 with a single apply.
- **Reset mid-operation:** all state returns to the reset values immediately, including any pending setting or busy count.

## Timing
- Address write at edge N: `wr_addr` and `pend` are valid after N. `div_setting` changes at the first edge M > N where `pres_tick = 1`.
- Data write at edge N:
  - `wr_stb` is high for the cycle N..N+1, with `wr_data` and `wr_addr` stable in that cycle.
  - `busy` rises after N+1 (registered compare).
  - `busy` falls one `clk` after the edge of the `BUSY_CNT`-th subsequent `pres_tick`.
- Busy sequencing is not enforced: the CPU is expected to poll `busy`, and writes issued while `busy` is high are still accepted.
- `div_setting` never changes except on a `pres_tick` edge.
- At most one `div_setting` change per tick.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> `div_setting` = 10, `busy` = 0 and `wr_stb` = 0 immediately; no change until `rst` drops.
- **Accumulation:** address write 0x2D, then 0x2E, with no tick in between; then `pres_tick` -> `div_setting` goes 10 -> 11 exactly on the tick edge; no intermediate value observed.
- **Clear and bank gating:** address write 0x2F, then `pres_tick` -> 00. Then, with `a1 = 1`, address write 0x2D followed by a tick -> remains 00.
- **Write/tick collision:** 0x2E written in the same cycle as `pres_tick` while `pend_vld` = 0 and `div_setting` = 00 -> no change on that tick; 01 on the next tick.
- **Busy timing:** `BUSY_CNT` = 4; data write 0xA5 after address 0x28 -> `wr_stb` pulse with `wr_addr` = 0x28 and `wr_data` = 0xA5. `busy` is high for 4 ticks; a second data write after 2 ticks extends busy to 6 ticks total.
- **Tick-coincident data write:** data write in the same cycle as `pres_tick` while the counter = 1 -> counter = `BUSY_CNT`; `busy` stays high with no low glitch.
